fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit, 8-opcode processor; sits directly upstream of the opcode decoder/control block. Owns the program counter and issues word-addressed requests to instruction memory, one outstanding at a time. Each returned word is held in an instruction register and presented downstream with valid/ready, with pre-split fields (op, rA, rB, rC, simm7, imm10). Accepts PC redirects (taken beq, jalr) resolved downstream and discards wrong-path fetches.

---
 rtl/risc16_pkg.sv | 45 ++++
 rtl/pc_target.sv | 30 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit, 8-opcode processor: opcodes, instruction
// field positions, PC-select encodings, fetch FSM states and the word type.
package risc16_pkg;

  typedef logic [15:0] word_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 13;
  localparam int unsigned RA_MSB    = 12;
  localparam int unsigned RA_LSB    = 10;
  localparam int unsigned RB_MSB    = 9;
  localparam int unsigned RB_LSB    = 7;
  localparam int unsigned RC_MSB    = 2;
  localparam int unsigned RC_LSB    = 0;
  localparam int unsigned SIMM7_MSB = 6;
  localparam int unsigned IMM10_MSB = 9;

  typedef enum logic [1:0] {
    PCSEL_INC  = 2'd0,
    PCSEL_BR   = 2'd1,
    PCSEL_JALR = 2'd2,
    PCSEL_RSVD = 2'd3
  } pcsel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  function automatic word_t sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/pc_target.sv
// Redirect target calculation: branch (base+1+sext(simm7)) or jalr (rb).
// Only branch and jalr selects report taken.
module pc_target
  import risc16_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [15:0] base_i,
  input  logic [6:0]  simm7_i,
  input  logic [15:0] rb_i,
  output logic [15:0] target_o,
  output logic        taken_o
);

  always_comb begin
    target_o = base_i + 16'd1 + sext7(simm7_i);
    taken_o  = 1'b0;
    unique case (pcsel_e'(sel_i))
      PCSEL_BR: begin
        target_o = base_i + 16'd1 + sext7(simm7_i);
        taken_o  = 1'b1;
      end
      PCSEL_JALR: begin
        target_o = rb_i;
        taken_o  = 1'b1;
      end
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, instruction
// register with valid/ready, redirects. Optional halt decode: FETCH_HALT_EN.
module fetch_unit
  import risc16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_pc,
  output logic [2:0]  out_op,
  output logic [2:0]  out_ra,
  output logic [2:0]  out_rb,
  output logic [2:0]  out_rc,
  output logic [6:0]  out_simm7,
  output logic [9:0]  out_imm10,
  input  logic        redir_valid,
  input  logic [1:0]  redir_sel,
  input  logic [15:0] redir_base,
  input  logic [6:0]  redir_simm7,
  input  logic [15:0] redir_rb,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        ir_q, ir_d;
  word_t        opc_q, opc_d;
  logic         drop_q, drop_d;

  word_t tgt;
  logic  tgt_taken;
  logic  redir_take;
  logic  gnt_ok;
  logic  is_halt;

  pc_target u_pc_target (
    .sel_i    (redir_sel),
    .base_i   (redir_base),
    .simm7_i  (redir_simm7),
    .rb_i     (redir_rb),
    .target_o (tgt),
    .taken_o  (tgt_taken)
  );

`ifdef FETCH_HALT_EN
  assign is_halt = (ir_q[OP_MSB:OP_LSB] == OP_JALR) && (ir_q[SIMM7_MSB:0] != '0);
`else
  assign is_halt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      opc_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opc_q   <= opc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    opc_d      = opc_q;
    drop_d     = drop_q;
    redir_take = redir_valid && tgt_taken && (state_q != ST_HALT);
    // A grant only moves to WAIT once any stale response has come back.
    gnt_ok     = imem_gnt && (!drop_q || imem_rvalid);

    if (drop_q && imem_rvalid)
      drop_d = 1'b0;

    unique case (state_q)
      ST_FETCH: if (gnt_ok) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid && !redir_take) begin
          ir_d    = imem_rdata;
          opc_d   = pc_q;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          pc_d    = opc_q + 16'd1;
          state_d = is_halt ? ST_HALT : ST_FETCH;
        end
      end
      default: state_d = state_q;
    endcase

    if (redir_take) begin
      pc_d    = tgt;
      state_d = ST_FETCH;
      if ((state_q == ST_FETCH && gnt_ok) || (state_q == ST_WAIT && !imem_rvalid))
        drop_d = 1'b1;
    end
  end

  always_comb begin
    imem_req  = (state_q == ST_FETCH) && !rst;
    imem_addr = pc_q;
    out_valid = (state_q == ST_HOLD);
    halted    = (state_q == ST_HALT);
    out_pc    = opc_q;
    out_op    = ir_q[OP_MSB:OP_LSB];
    out_ra    = ir_q[RA_MSB:RA_LSB];
    out_rb    = ir_q[RB_MSB:RB_LSB];
    out_rc    = ir_q[RC_MSB:RC_LSB];
    out_simm7 = ir_q[SIMM7_MSB:0];
    out_imm10 = ir_q[IMM10_MSB:0];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus hand sequences for async
// reset mid-transaction and the op=7 word (halt when FETCH_HALT_EN is defined).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [2:0]  out_op, out_ra, out_rb, out_rc;
  logic [6:0]  out_simm7;
  logic [9:0]  out_imm10;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_sel = '0;
  logic [15:0] redir_base = '0;
  logic [6:0]  redir_simm7 = '0;
  logic [15:0] redir_rb = '0;
  logic        halted;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
    .out_simm7(out_simm7), .out_imm10(out_imm10),
    .redir_valid(redir_valid), .redir_sel(redir_sel), .redir_base(redir_base),
    .redir_simm7(redir_simm7), .redir_rb(redir_rb), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv;
    logic [15:0] rdata;
    logic        rdy, dv;
    logic [1:0]  sel;
    logic [15:0] base;
    logic [6:0]  simm;
    logic [15:0] rb;
    logic        ereq;
    logic [15:0] eaddr;
    logic        evalid;
    logic [15:0] epc, eir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic g, logic rv, logic [15:0] rd, logic rdy,
                              logic dv, logic [1:0] sel, logic [15:0] base,
                              logic [6:0] sm, logic [15:0] rb, logic er,
                              logic [15:0] ea, logic ev, logic [15:0] ep,
                              logic [15:0] ei);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.dv = dv; v.sel = sel;
    v.base = base; v.simm = sm; v.rb = rb; v.ereq = er; v.eaddr = ea;
    v.evalid = ev; v.epc = ep; v.eir = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_fields(input string nm, input logic [15:0] pc, input logic [15:0] ir);
    logic [15:0] w;
    w = ir;
    chk({nm, " out_pc"},    out_pc, pc);
    chk({nm, " out_op"},    16'(out_op), 16'(w[15:13]));
    chk({nm, " out_ra"},    16'(out_ra), 16'(w[12:10]));
    chk({nm, " out_rb"},    16'(out_rb), 16'(w[9:7]));
    chk({nm, " out_rc"},    16'(out_rc), 16'(w[2:0]));
    chk({nm, " out_simm7"}, 16'(out_simm7), 16'(w[6:0]));
    chk({nm, " out_imm10"}, 16'(out_imm10), 16'(w[9:0]));
  endtask

  task automatic idle_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    redir_valid = 1'b0; redir_sel = '0; redir_base = '0; redir_simm7 = '0;
    redir_rb = '0;
  endtask

  initial begin
    // gnt rv rdata  rdy | dv sel base  simm  rb    | req addr   vld pc     ir
    vecs.push_back(mk(1,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h0000,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'h2485,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0000,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0000,1,16'h0000,16'h2485));
    vecs.push_back(mk(1,1,16'hFFFF,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0000,1,16'h0000,16'h2485));
    vecs.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0000,1,16'h0000,16'h2485));
    vecs.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0000,1,16'h0000,16'h2485));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0000,1,16'h0000,16'h2485));
    vecs.push_back(mk(1,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h0001,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0, 1,1,16'h0010,7'h7E,16'h0000, 0,16'h0001,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h000F,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'hDEAD,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h000F,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h000F,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'h4C0A,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'h000F,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1, 1,3,16'h0000,7'h00,16'h0000, 0,16'h000F,1,16'h000F,16'h4C0A));
    vecs.push_back(mk(1,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h0010,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'h1234,0, 1,2,16'h0000,7'h00,16'hFFFF, 0,16'h0010,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'hFFFF,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'h6081,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'hFFFF,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'hFFFF,7'h00,16'h0000, 0,16'hFFFF,1,16'hFFFF,16'h6081));
    vecs.push_back(mk(1,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h0000,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'hE001,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0000,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1, 1,1,16'h0020,7'h05,16'h0000, 0,16'h0000,1,16'h0000,16'hE001));
    vecs.push_back(mk(1,0,16'h0000,0, 1,2,16'h0000,7'h00,16'h0100, 1,16'h0026,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'hBEEF,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h0100,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h0100,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'hA5C3,0, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0100,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,16'h0000,7'h00,16'h0000, 0,16'h0100,1,16'h0100,16'hA5C3));
    vecs.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h0101,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,1,16'h7777,0, 0,0,16'h0000,7'h00,16'h0000, 1,16'h0101,0,16'h0000,16'h0000));

    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("reset imem_req",  16'(imem_req), 16'h0);
    chk("reset out_valid", 16'(out_valid), 16'h0);
    chk("reset halted",    16'(halted), 16'h0);
    chk("reset imem_addr", imem_addr, 16'h0000);
    chk_fields("reset", 16'h0000, 16'h0000);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      imem_gnt    = vecs[i].gnt;
      imem_rvalid = vecs[i].rv;
      imem_rdata  = vecs[i].rdata;
      out_ready   = vecs[i].rdy;
      redir_valid = vecs[i].dv;
      redir_sel   = vecs[i].sel;
      redir_base  = vecs[i].base;
      redir_simm7 = vecs[i].simm;
      redir_rb    = vecs[i].rb;
      #1;
      chk($sformatf("row%0d imem_req", i),  16'(imem_req), 16'(vecs[i].ereq));
      chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].eaddr);
      chk($sformatf("row%0d out_valid", i), 16'(out_valid), 16'(vecs[i].evalid));
      chk($sformatf("row%0d halted", i),    16'(halted), 16'h0);
      if (vecs[i].evalid)
        chk_fields($sformatf("row%0d", i), vecs[i].epc, vecs[i].eir);
      @(negedge clk);
    end

    // Async reset while a request is outstanding; its response must be ignored.
    idle_inputs();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #1 chk("pre-reset wait req", 16'(imem_req), 16'h0);
    #1 rst = 1'b1;
    #1;
    chk("async reset req",   16'(imem_req), 16'h0);
    chk("async reset valid", 16'(out_valid), 16'h0);
    chk("async reset addr",  imem_addr, 16'h0000);
    chk("async reset out_pc", out_pc, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 16'hBEEF;
    #1;
    chk("post-reset req",  16'(imem_req), 16'h1);
    chk("post-reset addr", imem_addr, 16'h0000);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("stale rvalid ignored req",   16'(imem_req), 16'h1);
    chk("stale rvalid ignored valid", 16'(out_valid), 16'h0);

    // Fetch op=7 word 16'hE001 and accept it.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hE001;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("E001 valid", 16'(out_valid), 16'h1);
    chk("E001 op",    16'(out_op), 16'h0007);
    chk("E001 simm7", 16'(out_simm7), 16'h0001);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
`ifdef FETCH_HALT_EN
    chk("halt halted", 16'(halted), 16'h1);
    chk("halt req",    16'(imem_req), 16'h0);
    redir_valid = 1'b1; redir_sel = 2'd2; redir_rb = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("halt hold%0d halted", k), 16'(halted), 16'h1);
      chk($sformatf("halt hold%0d req", k),    16'(imem_req), 16'h0);
      chk($sformatf("halt hold%0d valid", k),  16'(out_valid), 16'h0);
    end
    redir_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("halt recover halted", 16'(halted), 16'h0);
    chk("halt recover req",    16'(imem_req), 16'h1);
    chk("halt recover addr",   imem_addr, 16'h0000);
`else
    chk("no-halt halted", 16'(halted), 16'h0);
    chk("no-halt req",    16'(imem_req), 16'h1);
    chk("no-halt addr",   imem_addr, 16'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
